// File: rtl/sram_model_pkg.sv
// Shared types, sizes and lane helpers for the 1rw write-masked SRAM responder.
// The bench's scoreboard uses the same helpers to build expected words.
package sram_model_pkg;

    localparam int WORD_SIZE  = 2;
    localparam int ADDR_WIDTH = 4;
    localparam int NUM_WMASKS = 2;
    localparam int LANE_W     = WORD_SIZE / NUM_WMASKS;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    typedef logic [WORD_SIZE-1:0]  word_t;
    typedef logic [NUM_WMASKS-1:0] mask_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    // Replace every lane whose mask bit is set with the matching lane of new_word.
    function automatic word_t lane_merge(input word_t old_word, input word_t new_word,
                                         input mask_t mask);
        word_t res;
        res = old_word;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (mask[i]) begin
                res[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
            end
        end
        return res;
    endfunction

    function automatic word_t mask_unwritten(input word_t data, input word_t flags);
        word_t res;
        for (int i = 0; i < WORD_SIZE; i++) begin
            res[i] = flags[i] ? data[i] : 1'bx;
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sram_sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk0,
    input  logic                 rst0,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/sram_1rw_wmask_model.sv
// Behavioural memory-side responder for the OpenRAM csb0/web0/wmask0 1rw port.
// Tracks per-bit written flags so unwritten bits read back as X.
module sram_1rw_wmask_model
    import sram_model_pkg::*;
#(
    parameter int WORD_SIZE  = sram_model_pkg::WORD_SIZE,
    parameter int ADDR_WIDTH = sram_model_pkg::ADDR_WIDTH,
    parameter int NUM_WMASKS = sram_model_pkg::NUM_WMASKS,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [WORD_SIZE-1:0]  din0,
    output logic [WORD_SIZE-1:0]  dout0,
    output logic [CNT_WIDTH-1:0]  rd_cnt,
    output logic [CNT_WIDTH-1:0]  wr_cnt,
    output logic                  err0
);

    word_t mem_q  [DEPTH];
    word_t flag_q [DEPTH];
    word_t dout_q;
    word_t dout_d;
    logic  err_q;
    logic  err_d;

    logic  access;
    logic  err_hit;
    logic  do_write;
    logic  do_read;
    word_t mem_wdata;
    word_t flag_wdata;

    always_comb begin
        // An X on csb0 still counts as an attempted access.
        access     = (csb0 !== 1'b1);
        err_hit    = access && ($isunknown({csb0, web0, addr0}) ||
                                ((web0 === 1'b0) && $isunknown(wmask0)));
        do_write   = access && !err_hit && (web0 == 1'b0);
        do_read    = access && !err_hit && (web0 == 1'b1);
        mem_wdata  = lane_merge(mem_q[addr0], din0, wmask0);
        flag_wdata = lane_merge(flag_q[addr0], '1, wmask0);

        dout_d = dout_q;
        err_d  = err_q | err_hit;
        if (err_hit) begin
            dout_d = 'x;
        end else if (do_read) begin
            dout_d = mask_unwritten(mem_q[addr0], flag_q[addr0]);
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            dout_q <= 'x;
            err_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                flag_q[i] <= '0;
            end
        end else begin
            dout_q <= dout_d;
            err_q  <= err_d;
            if (do_write) begin
                flag_q[addr0] <= flag_wdata;
            end
        end
    end

    // NOTE: the data array is deliberately not reset; cleared flags already hide stale contents.
    always_ff @(posedge clk0) begin
        if (!rst0 && do_write) begin
            mem_q[addr0] <= mem_wdata;
        end
    end

    sram_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_rd_cnt (
        .clk0 (clk0),
        .rst0 (rst0),
        .inc  (do_read),
        .cnt  (rd_cnt)
    );

    sram_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wr_cnt (
        .clk0 (clk0),
        .rst0 (rst0),
        .inc  (do_write),
        .cnt  (wr_cnt)
    );

    assign dout0 = dout_q;
    assign err0  = err_q;

endmodule

// File: tb/tb_sram_1rw_wmask_model.sv
// Directed bench for sram_1rw_wmask_model: masked writes, X on unwritten bits,
// idle/write hold, reset priority, counter saturation and the sticky error flag.
module tb_sram_1rw_wmask_model;

    localparam int CW = 2;

    logic          clk0 = 1'b0;
    logic          rst0;
    logic          csb0;
    logic          web0;
    logic [1:0]    wmask0;
    logic [3:0]    addr0;
    logic [1:0]    din0;
    logic [1:0]    dout0;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] wr_cnt;
    logic          err0;

    int n_checks = 0;
    int n_pass   = 0;
    bit four_state;

    sram_1rw_wmask_model #(.CNT_WIDTH(CW)) dut (
        .clk0   (clk0),
        .rst0   (rst0),
        .csb0   (csb0),
        .web0   (web0),
        .wmask0 (wmask0),
        .addr0  (addr0),
        .din0   (din0),
        .dout0  (dout0),
        .rd_cnt (rd_cnt),
        .wr_cnt (wr_cnt),
        .err0   (err0)
    );

    always #5 clk0 = ~clk0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Compare only the bits expected to be known.
    task automatic check_data(input string tag, input logic [1:0] care, input logic [1:0] val);
        check(tag, {30'b0, dout0 & care}, {30'b0, val & care});
    endtask

    // All-X readback: only a four-state simulator can see the X bits.
    task automatic check_unknown(input string tag);
        check(tag, {31'b0, $isunknown(dout0)}, {31'b0, four_state});
    endtask

    task automatic check_cnts(input string tag, input int rd, input int wr, input logic err);
        check({tag, "_rd"}, {30'b0, rd_cnt}, rd);
        check({tag, "_wr"}, {30'b0, wr_cnt}, wr);
        check({tag, "_err"}, {31'b0, err0}, {31'b0, err});
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic go_idle();
        csb0 = 1'b1; web0 = 1'b1; wmask0 = 2'b00; din0 = 2'b00; addr0 = 4'h0;
    endtask

    task automatic do_wr(input logic [3:0] a, input logic [1:0] d, input logic [1:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
        tick();
        go_idle();
    endtask

    task automatic do_rd(input logic [3:0] a);
        csb0 = 1'b0; web0 = 1'b1; addr0 = a; din0 = 2'b11; wmask0 = 2'b11;
        tick();
        go_idle();
    endtask

    initial begin
        logic [1:0] probe;
        probe      = 2'bx1;
        four_state = $isunknown(probe);

        go_idle();
        rst0 = 1'b1;
        tick();
        tick();
        rst0 = 1'b0;
        check_cnts("reset", 0, 0, 1'b0);

        // Masked write of the upper lane only.
        do_wr(4'h1, 2'b10, 2'b10);
        do_rd(4'h1);
        check_data("mask_a1", 2'b10, 2'b10);
        check_cnts("mask", 1, 1, 1'b0);

        // Unwritten word and lower-lane-only word.
        do_wr(4'hC, 2'b01, 2'b01);
        do_rd(4'h0);
        check_unknown("unwr_a0");
        do_rd(4'hC);
        check_data("lane0_aC", 2'b01, 2'b01);
        check_cnts("unwr", 3, 2, 1'b0);

        // Fill the lower lane of addr 1; upper lane keeps its earlier 1.
        do_wr(4'h1, 2'b01, 2'b01);
        do_rd(4'h0);
        check_unknown("fill_a0");
        do_rd(4'h1);
        check_data("fill_a1", 2'b11, 2'b11);
        check_cnts("fill_sat", 3, 3, 1'b0);

        // Idle cycles and a write both leave dout0 alone.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_data("idle_hold", 2'b11, 2'b11);
        end
        check_cnts("idle", 3, 3, 1'b0);
        do_wr(4'h5, 2'b00, 2'b11);
        check_data("wr_hold", 2'b11, 2'b11);

        // Reset wins over a simultaneous write.
        rst0 = 1'b1; csb0 = 1'b0; web0 = 1'b0; addr0 = 4'h1; din0 = 2'b11; wmask0 = 2'b11;
        tick();
        rst0 = 1'b0;
        go_idle();
        check_cnts("rst_wr", 0, 0, 1'b0);
        do_rd(4'h1);
        check_unknown("rst_a1");
        check_cnts("rst_rd", 1, 0, 1'b0);

        // Zero-mask write counts but writes nothing.
        do_wr(4'h1, 2'b11, 2'b00);
        check_cnts("zmask_wr", 1, 1, 1'b0);
        do_rd(4'h1);
        check_unknown("zmask_a1");
        check_cnts("zmask_rd", 2, 1, 1'b0);

        // Read counter saturates at 3.
        for (int i = 0; i < 5; i++) do_rd(4'h1);
        check_cnts("sat", 3, 1, 1'b0);

        // Unknown address: sticky error, X data, no count.
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'bxxxx; wmask0 = 2'b00; din0 = 2'b00;
        tick();
        go_idle();
        check_unknown("err_dout");
        check_cnts("err", 3, 1, four_state);
        do_wr(4'h2, 2'b11, 2'b11);
        check_cnts("err_sticky", 3, 2, four_state);
        do_rd(4'h2);
        check_data("after_err_a2", 2'b11, 2'b11);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        check_cnts("err_clear", 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
